// File: rtl/countdown_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer.
package countdown_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned ONES_MAX     = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Display digit packing, same layout as the stopwatch chain.
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clamped load and wrap-to-MAX borrow.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Dec,
  input  logic               Load,
  input  logic [DIGIT_W-1:0] D,
  output logic [DIGIT_W-1:0] Q,
  output logic               Borrow
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] d_clamped;

  assign d_clamped = (D > MAX_V) ? MAX_V : D;
  assign Borrow    = Dec && (Q == '0);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Q <= '0;
    end else if (Load) begin
      Q <= d_clamped;
    end else if (Dec) begin
      Q <= (Q == '0) ? MAX_V : Q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: command FSM, 1 s prescaler, zero detect, Done pulse.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned PRESC_W       = 27
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        Clear,
  input  logic        Load,
  input  logic        Start,
  input  logic        Stop,
  input  logic [15:0] Preset,
  output logic [15:0] Q,
  output logic        Running,
  output logic        Expired,
  output logic        Done
);

  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICKS_PER_SEC - 1);

  logic [1:0]         state_r, state_nxt;
  logic [PRESC_W-1:0] presc_r, presc_nxt;
  logic               tick;
  logic               dig_clr;
  logic               dig_ld;
  logic               done_nxt;
  logic               q_nz;
  logic               q_one;

  bcd_time_t preset_t;
  bcd_time_t load_t;
  bcd_time_t q_t;
  logic [3:0] borrow;

  assign preset_t = bcd_time_t'(Preset);
  assign load_t   = dig_clr ? bcd_time_t'(16'h0000) : preset_t;
  assign Q        = q_t;
  assign q_nz     = (q_t != bcd_time_t'(16'h0000));
  // A decrement lands on 00:00 only from 00:01.
  assign q_one    = (q_t == bcd_time_t'(16'h0001));

  // Command priority Clear > Load > Stop > Start, then RUN counting.
  always_comb begin
    state_nxt = state_r;
    presc_nxt = presc_r;
    tick      = 1'b0;
    dig_clr   = 1'b0;
    dig_ld    = 1'b0;
    done_nxt  = 1'b0;
    if (Clear) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
      dig_clr   = 1'b1;
    end else if (Load && (state_r != ST_RUN)) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
      dig_ld    = 1'b1;
    end else if (Stop && (state_r == ST_RUN)) begin
      state_nxt = ST_PAUSE;
    end else if (Start && q_nz && ((state_r == ST_IDLE) || (state_r == ST_PAUSE))) begin
      state_nxt = ST_RUN;
      if (state_r == ST_IDLE) begin
        presc_nxt = '0;
      end
    end else if (state_r == ST_RUN) begin
      if (presc_r == PRESC_TERM) begin
        presc_nxt = '0;
        tick      = 1'b1;
        if (q_one) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end else begin
        presc_nxt = presc_r + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      presc_r <= '0;
      Running <= 1'b0;
      Expired <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      presc_r <= presc_nxt;
      Running <= (state_nxt == ST_RUN);
      Expired <= (state_nxt == ST_DONE);
      Done    <= done_nxt;
    end
  end

  bcd_down_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .Reset_n(Reset_n), .Dec(tick), .Load(dig_clr | dig_ld),
    .D(load_t.sec_ones), .Q(q_t.sec_ones), .Borrow(borrow[0])
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .Reset_n(Reset_n), .Dec(borrow[0]), .Load(dig_clr | dig_ld),
    .D(load_t.sec_tens), .Q(q_t.sec_tens), .Borrow(borrow[1])
  );

  bcd_down_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .Reset_n(Reset_n), .Dec(borrow[1]), .Load(dig_clr | dig_ld),
    .D(load_t.min_ones), .Q(q_t.min_ones), .Borrow(borrow[2])
  );

  // Top digit never borrows while running: 00:00 is caught one step earlier.
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_min_tens (
    .clk(clk), .Reset_n(Reset_n), .Dec(borrow[2]), .Load(dig_clr | dig_ld),
    .D(load_t.min_tens), .Q(q_t.min_tens), .Borrow(borrow[3])
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

  logic        clk;
  logic        Reset_n;
  logic        Clear;
  logic        Load;
  logic        Start;
  logic        Stop;
  logic [15:0] Preset;
  logic [15:0] Q;
  logic        Running;
  logic        Expired;
  logic        Done;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (
    .clk(clk), .Reset_n(Reset_n), .Clear(Clear), .Load(Load),
    .Start(Start), .Stop(Stop), .Preset(Preset), .Q(Q),
    .Running(Running), .Expired(Expired), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic c, input logic l, input logic s, input logic p);
    Clear = c; Load = l; Start = s; Stop = p;
    cyc();
    Clear = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    Clear = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
    Preset = 16'h0000;
    #12;
    check("rst_q", Q, 16'h0000);
    check("rst_run", 16'(Running), 16'h0);
    check("rst_exp", 16'(Expired), 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    @(negedge clk);
    Reset_n = 1'b1;
    cyc();

    // 1: 00:03 runs down to 00:00
    Preset = 16'h0003;
    pulse(0, 1, 0, 0);
    check("t1_load", Q, 16'h0003);
    pulse(0, 0, 1, 0);
    check("t1_run", 16'(Running), 16'h1);
    cyc(3);
    check("t1_pre", Q, 16'h0003);
    cyc();
    check("t1_q2", Q, 16'h0002);
    cyc(4);
    check("t1_q1", Q, 16'h0001);
    cyc(3);
    check("t1_nodone", 16'(Done), 16'h0);
    cyc();
    check("t1_q0", Q, 16'h0000);
    check("t1_done", 16'(Done), 16'h1);
    check("t1_exp", 16'(Expired), 16'h1);
    check("t1_runlo", 16'(Running), 16'h0);
    cyc();
    check("t1_done1cyc", 16'(Done), 16'h0);
    check("t1_exphold", 16'(Expired), 16'h1);
    pulse(0, 0, 1, 0);
    check("t1_startdone", 16'(Running), 16'h0);
    check("t1_qhold", Q, 16'h0000);

    // 2: borrow across every digit, then Load ignored in RUN
    Preset = 16'h1000;
    pulse(0, 1, 0, 0);
    check("t2_expclr", 16'(Expired), 16'h0);
    pulse(0, 0, 1, 0);
    cyc(4);
    check("t2_0959", Q, 16'h0959);
    cyc(4);
    check("t2_0958", Q, 16'h0958);
    Preset = 16'h0300;
    pulse(0, 1, 0, 0);
    check("t6_ldrun", Q, 16'h0958);
    cyc(3);
    check("t6_ldrun_dec", Q, 16'h0957);
    check("t6_ldrun_run", 16'(Running), 16'h1);
    pulse(1, 0, 0, 0);
    check("t2_clr", Q, 16'h0000);
    check("t2_clr_run", 16'(Running), 16'h0);

    // 3: pause keeps prescaler phase
    Preset = 16'h0005;
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    cyc(6);
    check("t3_q4", Q, 16'h0004);
    pulse(0, 0, 0, 1);
    check("t3_pause", 16'(Running), 16'h0);
    cyc(5);
    check("t3_hold", Q, 16'h0004);
    pulse(0, 0, 1, 0);
    check("t3_resume", 16'(Running), 16'h1);
    cyc();
    check("t3_resume1", Q, 16'h0004);
    cyc();
    check("t3_resume2", Q, 16'h0003);
    // Stop at terminal count suppresses the decrement
    cyc(3);
    pulse(0, 0, 0, 1);
    check("t3_stopterm", Q, 16'h0003);
    pulse(0, 0, 1, 0);
    check("t3_restart", Q, 16'h0003);
    cyc();
    check("t3_termtick", Q, 16'h0002);
    pulse(0, 0, 0, 1);
    // 6: Clear beats Start
    pulse(1, 0, 1, 0);
    check("t6_clrstart_q", Q, 16'h0000);
    check("t6_clrstart_run", 16'(Running), 16'h0);
    cyc();
    check("t6_idle", 16'(Running), 16'h0);

    // 4: clamp and zero-start guard
    Preset = 16'h7A9F;
    pulse(0, 1, 0, 0);
    check("t4_clamp", Q, 16'h5959);
    Preset = 16'h0000;
    pulse(0, 1, 0, 0);
    check("t4_zero", Q, 16'h0000);
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      check("t4_run", 16'(Running), 16'h0);
      check("t4_done", 16'(Done), 16'h0);
      cyc();
    end

    // 5: async reset mid-RUN
    Preset = 16'h0003;
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    cyc(4);
    check("t5_q2", Q, 16'h0002);
    #3;
    Reset_n = 1'b0;
    #1;
    check("t5_rst_q", Q, 16'h0000);
    check("t5_rst_run", 16'(Running), 16'h0);
    check("t5_rst_done", 16'(Done), 16'h0);
    @(negedge clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t5_idle_run", 16'(Running), 16'h0);
      check("t5_idle_q", Q, 16'h0000);
      check("t5_idle_done", 16'(Done), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
